// File: rtl/riscvsys_pkg.sv
// Shared definitions for the riscvsys memory/MMIO block: MMIO addresses,
// control-port tag and codes, stall-mode encoding, FSM states and the
// xorshift32 step function.
package riscvsys_pkg;

  // Character output channel k lives at CHR_BASE + 4*k
  localparam logic [31:0] CHR_BASE  = 32'h1000_0000;
  // Control port; only writes carrying CTRL_TAG in bits [31:8] are honoured
  localparam logic [31:0] CTRL_ADDR = 32'h2000_0000;
  localparam logic [23:0] CTRL_TAG  = 24'hacce55;

  // Control codes carried in bits [7:0] of a tagged control write
  localparam logic [7:0] CTRL_NOP      = 8'h00;
  localparam logic [7:0] CTRL_ERROR    = 8'h01;
  localparam logic [7:0] CTRL_DUMP_OFF = 8'h02;
  localparam logic [7:0] CTRL_DUMP_ON  = 8'h03;
  localparam logic [7:0] CTRL_HALT     = 8'h04;
  localparam logic [7:0] CTRL_PASS     = 8'h05;

  // Ready latency source
  typedef enum logic [1:0] {
    STALL_NONE  = 2'd0,
    STALL_FIXED = 2'd1,
    STALL_PRNG  = 2'd2
  } stall_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // One xorshift32 step (13, 17, 5)
  function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/riscvsys_xorshift32.sv
// Free-running xorshift32 generator.
// Ports: i_clk clock; i_rst sync active-low reset (loads SEED);
//        i_en advance enable; o_state current 32-bit state.
module riscvsys_xorshift32
  import riscvsys_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd314159265
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [31:0] o_state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // Next state
  always_comb begin
    state_d = state_q;
    if (i_en) begin
      state_d = xorshift32_next(state_q);
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/riscvsys_mem.sv
// Simulation-system memory: word RAM behind a valid/ready handshake with
// optional stall injection, plus MMIO character channels, a tagged control
// port (dump enable) and a sticky out-of-bounds write flag.
// Ports: i_clk clock; i_rst sync active-low reset;
//        i_valid/i_instr/i_addr/i_wdata/i_wstrb request (wstrb 0 = read);
//        o_ready handshake (combinational); o_rdata read data (combinational);
//        o_chr_valid/o_chr character strobe per channel and byte;
//        o_ctrl_valid/o_ctrl_code control strobe and code;
//        o_dumpon dump enable; o_oob sticky unmapped-write flag.
module riscvsys_mem
  import riscvsys_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 65536,
  parameter int unsigned STALL_MODE = 0,
  parameter int unsigned FIXED_LAT  = 2,
  parameter int unsigned RAND_W     = 2,
  parameter int unsigned PRNG_SEED  = 314159265,
  parameter int unsigned N_CHAN     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_instr,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  output logic              o_ready,
  output logic [31:0]       o_rdata,
  output logic [N_CHAN-1:0] o_chr_valid,
  output logic [7:0]        o_chr,
  output logic              o_ctrl_valid,
  output logic [7:0]        o_ctrl_code,
  output logic              o_dumpon,
  output logic              o_oob
);

  localparam int unsigned AW        = $clog2(MEM_BYTES);
  localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
  localparam int unsigned CNT_W     = (RAND_W > 4) ? RAND_W : 4;
  localparam int unsigned CHR_SPAN  = 4 * N_CHAN;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  lat_c;
  logic              ready_c;
  logic              hs_c;
  logic              wr_c;
  logic [31:0]       prng_state;

  logic [31:0]       mem_q [MEM_WORDS];
  logic [AW-3:0]     word_idx_c;
  logic              in_ram_c;
  logic [31:0]       chr_off_c;
  logic              chr_hit_c;
  logic [2:0]        chr_idx_c;
  logic              ctrl_hit_c;

  logic [N_CHAN-1:0] chr_valid_q, chr_valid_d;
  logic [7:0]        chr_q, chr_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic [7:0]        ctrl_code_q, ctrl_code_d;
  logic              dumpon_q, dumpon_d;
  logic              oob_q, oob_d;

  // Fetch flag has no functional effect; PRNG bits only matter in PRNG mode
  logic              unused_c;
  assign unused_c = ^{i_instr, prng_state};

  // Latency source, always running so stall patterns are reproducible
  riscvsys_xorshift32 #(
    .SEED (32'(PRNG_SEED))
  ) u_prng (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (1'b1),
    .o_state (prng_state)
  );

  // Address decode
  assign in_ram_c   = i_addr < 32'(MEM_BYTES);
  assign word_idx_c = i_addr[AW-1:2];
  assign chr_off_c  = i_addr - CHR_BASE;
  assign chr_hit_c  = (chr_off_c < 32'(CHR_SPAN)) && (chr_off_c[1:0] == 2'b00);
  assign chr_idx_c  = chr_off_c[4:2];
  assign ctrl_hit_c = i_addr == CTRL_ADDR;

  // Latency for a request first seen in IDLE
  always_comb begin
    lat_c = '0;
    if (STALL_MODE == 32'(STALL_FIXED)) begin
      lat_c = CNT_W'(FIXED_LAT);
    end else if (STALL_MODE == 32'(STALL_PRNG)) begin
      lat_c = CNT_W'(prng_state[RAND_W-1:0]);
    end
  end

  // Handshake FSM: next state, counter and ready
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (lat_c == '0) begin
            ready_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = lat_c - CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (!i_valid) begin
          // Requester withdrew: drop the request with no side effects
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          ready_c = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // A request in flight when reset hits is abandoned, never completed
    if (!i_rst) begin
      ready_c = 1'b0;
    end
  end

  assign hs_c = i_valid && ready_c;
  assign wr_c = hs_c && (i_wstrb != 4'b0000);

  // MMIO side effects of a handshaked write outside RAM
  always_comb begin
    chr_valid_d  = '0;
    chr_d        = chr_q;
    ctrl_valid_d = 1'b0;
    ctrl_code_d  = ctrl_code_q;
    dumpon_d     = dumpon_q;
    oob_d        = oob_q;
    if (wr_c && !in_ram_c) begin
      if (chr_hit_c) begin
        for (int k = 0; k < N_CHAN; k++) begin
          chr_valid_d[k] = chr_idx_c == 3'(k);
        end
        chr_d = i_wdata[7:0];
      end else if (ctrl_hit_c) begin
        // Untagged control writes are silently dropped
        if (i_wdata[31:8] == CTRL_TAG) begin
          ctrl_valid_d = 1'b1;
          ctrl_code_d  = i_wdata[7:0];
          if (i_wdata[7:0] == CTRL_DUMP_OFF) begin
            dumpon_d = 1'b0;
          end else if (i_wdata[7:0] == CTRL_DUMP_ON) begin
            dumpon_d = 1'b1;
          end
        end
      end else begin
        oob_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      chr_valid_q  <= '0;
      chr_q        <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_code_q  <= '0;
      dumpon_q     <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      chr_valid_q  <= chr_valid_d;
      chr_q        <= chr_d;
      ctrl_valid_q <= ctrl_valid_d;
      ctrl_code_q  <= ctrl_code_d;
      dumpon_q     <= dumpon_d;
      oob_q        <= oob_d;
    end
  end

  // RAM byte writes at the handshake edge; contents survive reset
  always_ff @(posedge i_clk) begin
    if (wr_c && in_ram_c) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) begin
          mem_q[word_idx_c][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Asynchronous read, so a same-cycle write still returns the old word
  assign o_rdata      = in_ram_c ? mem_q[word_idx_c] : 32'h0;
  assign o_ready      = ready_c;
  assign o_chr_valid  = chr_valid_q;
  assign o_chr        = chr_q;
  assign o_ctrl_valid = ctrl_valid_q;
  assign o_ctrl_code  = ctrl_code_q;
  assign o_dumpon     = dumpon_q;
  assign o_oob        = oob_q;

endmodule

// File: tb/tb_riscvsys_mem.sv
// Directed bench for riscvsys_mem: three instances cover no stall, fixed
// latency 3 and PRNG latency; expected values are hand-computed, PRNG
// latencies come from a local xorshift32 reference.
module tb_riscvsys_mem;
  import riscvsys_pkg::*;

  localparam logic [31:0] SEED = 32'd314159265;

  logic        clk;
  logic        rst;
  logic        valid     [3];
  logic [31:0] addr      [3];
  logic [31:0] wdata     [3];
  logic [3:0]  wstrb     [3];
  logic        ready     [3];
  logic [31:0] rdata     [3];
  logic [1:0]  chr_valid [3];
  logic [7:0]  chr       [3];
  logic        ctrl_valid[3];
  logic [7:0]  ctrl_code [3];
  logic        dumpon    [3];
  logic        oob       [3];

  int          n_checks;
  int          n_fail;
  logic [31:0] ref_prng;

  riscvsys_mem #(.STALL_MODE(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .i_instr(1'b0),
    .i_addr(addr[0]), .i_wdata(wdata[0]), .i_wstrb(wstrb[0]),
    .o_ready(ready[0]), .o_rdata(rdata[0]), .o_chr_valid(chr_valid[0]),
    .o_chr(chr[0]), .o_ctrl_valid(ctrl_valid[0]), .o_ctrl_code(ctrl_code[0]),
    .o_dumpon(dumpon[0]), .o_oob(oob[0]));

  riscvsys_mem #(.STALL_MODE(1), .FIXED_LAT(3)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .i_instr(1'b0),
    .i_addr(addr[1]), .i_wdata(wdata[1]), .i_wstrb(wstrb[1]),
    .o_ready(ready[1]), .o_rdata(rdata[1]), .o_chr_valid(chr_valid[1]),
    .o_chr(chr[1]), .o_ctrl_valid(ctrl_valid[1]), .o_ctrl_code(ctrl_code[1]),
    .o_dumpon(dumpon[1]), .o_oob(oob[1]));

  riscvsys_mem #(.STALL_MODE(2), .RAND_W(2), .PRNG_SEED(314159265)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[2]), .i_instr(1'b1),
    .i_addr(addr[2]), .i_wdata(wdata[2]), .i_wstrb(wstrb[2]),
    .o_ready(ready[2]), .o_rdata(rdata[2]), .o_chr_valid(chr_valid[2]),
    .o_chr(chr[2]), .o_ctrl_valid(ctrl_valid[2]), .o_ctrl_code(ctrl_code[2]),
    .o_dumpon(dumpon[2]), .o_oob(oob[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ {s[18:0], 13'b0};
    t = t ^ {17'b0, t[31:17]};
    t = t ^ {t[26:0], 5'b0};
    return t;
  endfunction

  // Reference generator tracking the DUT PRNG cycle by cycle
  always @(posedge clk) begin
    if (!rst) ref_prng <= SEED;
    else      ref_prng <= ref_step(ref_prng);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request on instance d (called just after a posedge); returns
  // latency (-1 on timeout), data seen at the handshake and the reference
  // PRNG latency for the first request cycle. Returns just after the
  // handshake edge.
  task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output int lat, output logic [31:0] rd,
                        output int plat);
    int  c;
    bit  done;
    valid[d] = 1'b1;
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = ws;
    lat  = -1;
    rd   = 32'h0;
    plat = -1;
    c    = 0;
    done = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk);
      if (c == 0) plat = int'(ref_prng[1:0]);
      if (ready[d]) begin
        done = 1'b1;
        lat  = c;
        rd   = rdata[d];
      end else begin
        c++;
      end
    end
    @(posedge clk);
    #1;
    valid[d] = 1'b0;
    wstrb[d] = 4'h0;
  endtask

  initial begin
    int          lat, plat;
    logic [31:0] rd;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0; wstrb[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready",   32'(ready[0]),      32'h0);
    check_eq("rst_chr_v",   32'(chr_valid[0]),  32'h0);
    check_eq("rst_ctrl_v",  32'(ctrl_valid[0]), 32'h0);
    check_eq("rst_dumpon",  32'(dumpon[0]),     32'h0);
    check_eq("rst_oob",     32'(oob[0]),        32'h0);
    check_eq("rst_chr",     32'(chr[0]),        32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ---- no-stall instance ----
    do_req(0, 32'h100, 32'hdeadbeef, 4'hf, lat, rd, plat);
    check_eq("m0_wr_lat", 32'(lat), 32'h0);
    do_req(0, 32'h100, 32'h0, 4'h0, lat, rd, plat);
    check_eq("m0_rd_lat", 32'(lat), 32'h0);
    check_eq("m0_rd_data", rd, 32'hdeadbeef);
    do_req(0, 32'h100, 32'h12345678, 4'hf, lat, rd, plat);
    check_eq("m0_rmw_old", rd, 32'hdeadbeef);
    do_req(0, 32'h102, 32'h0, 4'h0, lat, rd, plat);
    check_eq("m0_rd_lowbits", rd, 32'h12345678);
    do_req(0, 32'h0001_0000, 32'h0, 4'h0, lat, rd, plat);
    check_eq("m0_rd_beyond", rd, 32'h0);

    do_req(0, 32'h1000_0004, 32'h0000_0041, 4'hf, lat, rd, plat);
    check_eq("chr1_valid", 32'(chr_valid[0]), 32'h2);
    check_eq("chr1_byte",  32'(chr[0]),       32'h41);
    @(posedge clk); #1;
    check_eq("chr1_pulse_end", 32'(chr_valid[0]), 32'h0);
    do_req(0, 32'h1000_0000, 32'h0000_005a, 4'h1, lat, rd, plat);
    check_eq("chr0_valid", 32'(chr_valid[0]), 32'h1);
    check_eq("chr0_byte",  32'(chr[0]),       32'h5a);

    do_req(0, 32'h2000_0000, 32'hacce5503, 4'hf, lat, rd, plat);
    check_eq("ctrl_valid",  32'(ctrl_valid[0]), 32'h1);
    check_eq("ctrl_code",   32'(ctrl_code[0]),  32'h03);
    check_eq("dump_on",     32'(dumpon[0]),     32'h1);
    @(posedge clk); #1;
    check_eq("ctrl_pulse_end", 32'(ctrl_valid[0]), 32'h0);
    do_req(0, 32'h2000_0000, 32'h12345602, 4'hf, lat, rd, plat);
    check_eq("ctrl_badtag_v",   32'(ctrl_valid[0]), 32'h0);
    check_eq("ctrl_badtag_dmp", 32'(dumpon[0]),     32'h1);
    check_eq("ctrl_badtag_oob", 32'(oob[0]),        32'h0);
    do_req(0, 32'h2000_0000, 32'hacce5502, 4'hf, lat, rd, plat);
    check_eq("dump_off", 32'(dumpon[0]), 32'h0);

    do_req(0, 32'h1000_0004, 32'h0, 4'h0, lat, rd, plat);
    check_eq("mmio_rd_data", rd, 32'h0);
    check_eq("mmio_rd_nochr", 32'(chr_valid[0]), 32'h0);

    do_req(0, 32'h0, 32'hcafef00d, 4'hf, lat, rd, plat);
    do_req(0, 32'h3000_0000, 32'h11111111, 4'hf, lat, rd, plat);
    check_eq("oob_set", 32'(oob[0]), 32'h1);
    do_req(0, 32'h0, 32'h0, 4'h0, lat, rd, plat);
    check_eq("oob_ram_kept", rd, 32'hcafef00d);
    check_eq("oob_sticky", 32'(oob[0]), 32'h1);

    // ---- fixed latency 3 instance ----
    do_req(1, 32'h40, 32'hffffffff, 4'hf, lat, rd, plat);
    check_eq("m1_fill_lat", 32'(lat), 32'h3);
    do_req(1, 32'h40, 32'h11223344, 4'b0101, lat, rd, plat);
    check_eq("m1_wr_lat", 32'(lat), 32'h3);
    do_req(1, 32'h40, 32'h0, 4'h0, lat, rd, plat);
    check_eq("m1_rd_lat",  32'(lat), 32'h3);
    check_eq("m1_rd_data", rd, 32'hff22ff44);

    // Withdrawn write must leave RAM untouched
    valid[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'h0; wstrb[1] = 4'hf;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid[1] = 1'b0; wstrb[1] = 4'h0;
    @(posedge clk); #1;
    do_req(1, 32'h40, 32'h0, 4'h0, lat, rd, plat);
    check_eq("m1_abort_lat",  32'(lat), 32'h3);
    check_eq("m1_abort_data", rd, 32'hff22ff44);

    do_req(1, 32'h3000_0000, 32'h0, 4'hf, lat, rd, plat);
    check_eq("m1_oob_set", 32'(oob[1]), 32'h1);

    // ---- PRNG latency instance: back-to-back reads ----
    for (int i = 0; i < 1000; i++) begin
      do_req(2, 32'(i * 4), 32'h0, 4'h0, lat, rd, plat);
      check_eq("m2_lat", 32'(lat), 32'(plat));
    end

    // ---- reset while waiting ----
    valid[1] = 1'b1; addr[1] = 32'h40; wstrb[1] = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstw_ready", 32'(ready[1]), 32'h0);
    @(posedge clk); #1;
    check_eq("rstw_fsm",   32'(dut1.state_q), 32'(ST_IDLE));
    check_eq("rstw_oob",   32'(oob[1]), 32'h0);
    check_eq("rstw_oob0",  32'(oob[0]), 32'h0);
    valid[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(1, 32'h40, 32'h0, 4'h0, lat, rd, plat);
    check_eq("post_rst_lat",  32'(lat), 32'h3);
    check_eq("post_rst_data", rd, 32'hff22ff44);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscvsys_mem.md
RISCVSYS_MEM -- requirements
Module: riscvsys_mem

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 65536, RAM size in bytes (power of two, >= 8).
REQ-002 SHALL have parameter STALL_MODE, default 0, ready latency mode: 0 none, 1 fixed, 2 PRNG.
REQ-003 SHALL have parameter FIXED_LAT, default 2, latency in cycles for STALL_MODE 1 (0..15).
REQ-004 SHALL have parameter RAND_W, default 2, PRNG latency width, giving latency 0..2^RAND_W-1.
REQ-005 SHALL have parameter PRNG_SEED, default 314159265, xorshift32 reset value (nonzero).
REQ-006 SHALL have parameter N_CHAN, default 2, number of character-output MMIO channels (1..8).
REQ-007 SHALL have these ports: i_clk in 1 clock; i_rst in 1 synchronous active-low reset.
REQ-008 SHALL have i_valid in 1 request; i_instr in 1 fetch flag (ignored functionally); i_addr in 32 byte address.
REQ-009 SHALL have i_wdata in 32 write data; i_wstrb in 4 byte strobes (0 = read); o_ready out 1 handshake; o_rdata out 32 read data.
REQ-010 SHALL have o_chr_valid out N_CHAN per-channel strobe; o_chr out 8 character; o_ctrl_valid out 1; o_ctrl_code out 8.
REQ-011 SHALL have o_dumpon out 1 dump enable; o_oob out 1 sticky out-of-bounds-write flag.

Function
REQ-012 SHALL define latency L as cycles from the first cycle i_valid is sampled high in IDLE to o_ready high; L=0 gives o_ready in the same cycle (combinational).
REQ-013 SHALL compute L as 0 (mode 0), FIXED_LAT (mode 1), or PRNG[RAND_W-1:0] sampled on that first cycle (mode 2).
REQ-014 SHALL use FSM IDLE->WAIT when i_valid and L>0, loading counter with L-1; WAIT decrements to 0; o_ready = (WAIT and cnt==0) or (IDLE and i_valid and L==0).
REQ-015 SHALL return to IDLE on the handshake (i_valid and o_ready); a new request is accepted in IDLE the following cycle.
REQ-016 SHALL abort to IDLE without side effects if i_valid drops while in WAIT.
REQ-017 SHALL advance the xorshift32 (<<13, >>17, <<5) every cycle while not in reset.
REQ-018 SHALL drive o_rdata = RAM word at i_addr[log2(MEM_BYTES)-1:2] when i_addr < MEM_BYTES, else 0; address bits [1:0] are ignored.
REQ-019 SHALL commit RAM writes per i_wstrb byte at the handshake clock edge; a read in the same cycle returns pre-write data.
REQ-020 SHALL, for a write with i_addr == 0x1000_0000 + 4*k (k < N_CHAN), pulse o_chr_valid[k] for one cycle after the handshake with o_chr = i_wdata[7:0].
REQ-021 SHALL, for a write to 0x2000_0000 with i_wdata[31:8] == 0xacce55, pulse o_ctrl_valid one cycle after the handshake with o_ctrl_code = i_wdata[7:0]; other data SHALL be ignored.
REQ-022 SHALL clear o_dumpon on ctrl code 0x02 and set it on 0x03; other codes SHALL leave it unchanged.
REQ-023 SHALL set o_oob on any handshaked write to an unmapped address, suppressing the write; o_oob SHALL hold until reset.
REQ-024 SHALL treat reads of MMIO/unmapped addresses as side-effect-free, returning 0.

Reset
REQ-025 SHALL, while i_rst is low at a clock edge, force FSM to IDLE, counter 0, PRNG to PRNG_SEED, o_chr_valid/o_ctrl_valid/o_dumpon/o_oob/o_chr/o_ctrl_code to 0.
REQ-026 SHALL hold o_ready low during reset, abandoning any in-flight request; RAM contents SHALL NOT be reset.

Structure
REQ-027 SHALL place the MMIO base addresses, the 0xacce55 tag, ctrl codes 0x00-0x05 and the stall-mode enum in package riscvsys_pkg.
REQ-028 SHALL implement the PRNG as sub-module riscvsys_xorshift32 (seed parameter, enable, 32-bit state output).

Verification
REQ-029 SHALL check mode 0: read 0x100 after preload 0xdeadbeef -> o_ready same cycle, o_rdata 0xdeadbeef.
REQ-030 SHALL check mode 1, FIXED_LAT 3: sw 0x11223344 with wstrb 0b0101 to 0x40 over 0xffffffff -> o_ready on 4th cycle, word reads 0xff22ff44.
REQ-031 SHALL check mode 2: 1000 back-to-back reads -> every latency in 0..3, sequence matches a reference xorshift32 from seed 314159265.
REQ-032 SHALL check writes 0x41 to 0x1000_0004 then 0xacce5503 to 0x2000_0000 -> o_chr_valid 0b10 with o_chr 0x41, o_ctrl_code 0x03, o_dumpon 1.
REQ-033 SHALL check a write to 0x3000_0000 -> o_oob 1 and RAM unchanged; assert i_rst low in WAIT -> o_ready 0, FSM IDLE, o_oob 0.
